// File: rtl/sram_like_arbiter.sv
// Round-robin merger of N SRAM-like requesters onto one downstream port.
// Issue-order channel IDs route each downstream response back to its owner.
module sram_like_arbiter #(
  parameter int CHANNEL_COUNT     = 2,
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int OUTSTANDING_DEPTH = 4
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [CHANNEL_COUNT-1:0]                upstream_request,
  input  logic [CHANNEL_COUNT-1:0]                upstream_write,
  input  logic [2*CHANNEL_COUNT-1:0]              upstream_size,
  input  logic [ADDRESS_WIDTH*CHANNEL_COUNT-1:0]  upstream_address,
  input  logic [DATA_WIDTH*CHANNEL_COUNT-1:0]     upstream_write_data,
  input  logic [DATA_WIDTH/8*CHANNEL_COUNT-1:0]   upstream_write_strobe,
  output logic [CHANNEL_COUNT-1:0]                upstream_address_ready,
  output logic [CHANNEL_COUNT-1:0]                upstream_data_ready,
  output logic [DATA_WIDTH-1:0]                   upstream_read_data,
  output logic                                    ram_request,
  output logic                                    ram_write,
  output logic [1:0]                              ram_size,
  output logic [ADDRESS_WIDTH-1:0]                ram_address,
  output logic [DATA_WIDTH-1:0]                   ram_write_data,
  output logic [DATA_WIDTH/8-1:0]                 ram_write_strobe,
  input  logic                                    ram_address_ready,
  input  logic                                    ram_data_ready,
  input  logic [DATA_WIDTH-1:0]                   ram_read_data,
  output logic                                    protocol_error
);

  localparam int STROBE_WIDTH = DATA_WIDTH / 8;
  localparam int IW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
  localparam int FW = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;
  localparam int CW = $clog2(OUTSTANDING_DEPTH + 1);

  logic [IW-1:0] ptr_r;
  logic          lock_r;
  logic [IW-1:0] lock_idx_r;
  logic [IW-1:0] id_fifo_r [OUTSTANDING_DEPTH];
  logic [FW-1:0] head_r;
  logic [FW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          error_r;

  logic                     grant_valid_s;
  logic [IW-1:0]            grant_s;
  logic [CHANNEL_COUNT-1:0] grant_onehot_s;
  logic                     full_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     orphan_s;
  logic [IW-1:0]            head_id_s;

  // Grant selection: locked channel wins, else first requester at or after the pointer.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = '0;
    if (lock_r) begin
      grant_valid_s = 1'b1;
      grant_s       = lock_idx_r;
    end else begin
      // Walk offsets from farthest to nearest so the nearest requester is the last write.
      for (int i = CHANNEL_COUNT - 1; i >= 0; i--) begin
        if (upstream_request[(int'(ptr_r) + i) % CHANNEL_COUNT]) begin
          grant_valid_s = 1'b1;
          grant_s       = IW'((int'(ptr_r) + i) % CHANNEL_COUNT);
        end else begin
          grant_valid_s = grant_valid_s;
          grant_s       = grant_s;
        end
      end
    end
  end

  assign grant_onehot_s = grant_valid_s ? (CHANNEL_COUNT'(1) << grant_s) : '0;

  // AND-OR mux of the granted channel's request fields; all zero without a grant.
  always_comb begin
    ram_write        = 1'b0;
    ram_size         = 2'b00;
    ram_address      = '0;
    ram_write_data   = '0;
    ram_write_strobe = '0;
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      ram_write        = ram_write | (grant_onehot_s[c] & upstream_write[c]);
      ram_size         = ram_size | ({2{grant_onehot_s[c]}} & upstream_size[2*c +: 2]);
      ram_address      = ram_address |
                         ({ADDRESS_WIDTH{grant_onehot_s[c]}} & upstream_address[c*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
      ram_write_data   = ram_write_data |
                         ({DATA_WIDTH{grant_onehot_s[c]}} & upstream_write_data[c*DATA_WIDTH +: DATA_WIDTH]);
      ram_write_strobe = ram_write_strobe |
                         ({STROBE_WIDTH{grant_onehot_s[c]}} & upstream_write_strobe[c*STROBE_WIDTH +: STROBE_WIDTH]);
    end
  end

  assign full_s      = (count_r == CW'(OUTSTANDING_DEPTH));
  assign ram_request = grant_valid_s & ~full_s & ~reset;
  assign push_s      = ram_request & ram_address_ready;
  assign pop_s       = ram_data_ready & (count_r != '0) & ~reset;
  assign orphan_s    = ram_data_ready & (count_r == '0) & ~reset;
  assign head_id_s   = id_fifo_r[head_r];

  assign upstream_address_ready = push_s ? grant_onehot_s : '0;
  assign upstream_data_ready    = pop_s ? (CHANNEL_COUNT'(1) << head_id_s) : '0;
  assign upstream_read_data     = ram_read_data;
  assign protocol_error         = error_r;

  // Pointer, lock, ID FIFO and sticky error state.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_r      <= '0;
      lock_r     <= 1'b0;
      lock_idx_r <= '0;
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      error_r    <= 1'b0;
    end else begin
      if (push_s) begin
        id_fifo_r[tail_r] <= grant_s;
        tail_r <= (tail_r == FW'(OUTSTANDING_DEPTH - 1)) ? '0 : tail_r + FW'(1);
        ptr_r  <= (grant_s == IW'(CHANNEL_COUNT - 1)) ? '0 : grant_s + IW'(1);
        lock_r <= 1'b0;
      end else if (ram_request) begin
        // Hold the stalled request steady until the downstream accepts it.
        lock_r     <= 1'b1;
        lock_idx_r <= grant_s;
      end else begin
        lock_r <= lock_r;
      end

      if (pop_s) begin
        head_r <= (head_r == FW'(OUTSTANDING_DEPTH - 1)) ? '0 : head_r + FW'(1);
      end else begin
        head_r <= head_r;
      end

      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase

      if (orphan_s) begin
        error_r <= 1'b1;
      end else begin
        error_r <= error_r;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scenario bench for sram_like_arbiter (3 channels, depth 4) plus a randomized
// run against a queue-based model of the arbitration and response-steering rules.
module tb_sram_like_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int D  = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    upstream_request, upstream_write;
  logic [2*N-1:0]  upstream_size;
  logic [AW*N-1:0] upstream_address;
  logic [DW*N-1:0] upstream_write_data;
  logic [SW*N-1:0] upstream_write_strobe;
  logic [N-1:0]    upstream_address_ready, upstream_data_ready;
  logic [DW-1:0]   upstream_read_data;
  logic            ram_request, ram_write;
  logic [1:0]      ram_size;
  logic [AW-1:0]   ram_address;
  logic [DW-1:0]   ram_write_data;
  logic [SW-1:0]   ram_write_strobe;
  logic            ram_address_ready, ram_data_ready;
  logic [DW-1:0]   ram_read_data;
  logic            protocol_error;

  int tests_run = 0;
  int tests_failed = 0;

  sram_like_arbiter #(
    .CHANNEL_COUNT(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING_DEPTH(D)
  ) dut (
    .clock(clock), .reset(reset),
    .upstream_request(upstream_request), .upstream_write(upstream_write),
    .upstream_size(upstream_size), .upstream_address(upstream_address),
    .upstream_write_data(upstream_write_data), .upstream_write_strobe(upstream_write_strobe),
    .upstream_address_ready(upstream_address_ready), .upstream_data_ready(upstream_data_ready),
    .upstream_read_data(upstream_read_data),
    .ram_request(ram_request), .ram_write(ram_write), .ram_size(ram_size),
    .ram_address(ram_address), .ram_write_data(ram_write_data),
    .ram_write_strobe(ram_write_strobe), .ram_address_ready(ram_address_ready),
    .ram_data_ready(ram_data_ready), .ram_read_data(ram_read_data),
    .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [AW-1:0] chan_addr(int c);
    return 32'hA000_0000 + 32'(c);
  endfunction

  task automatic load_fields();
    for (int c = 0; c < N; c++) begin
      upstream_address[c*AW +: AW]     = chan_addr(c);
      upstream_write_data[c*DW +: DW]  = 32'hD000_0000 + 32'(c);
      upstream_write_strobe[c*SW +: SW] = 4'hF;
      upstream_size[2*c +: 2]          = 2'b10;
    end
    upstream_write = '0;
  endtask

  task automatic idle_inputs();
    upstream_request  = '0;
    ram_address_ready = 1'b0;
    ram_data_ready    = 1'b0;
    ram_read_data     = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    upstream_request = 3'b111;
    ram_address_ready = 1'b1;
    ram_data_ready = 1'b1;
    @(negedge clock);
    tests_run++;
    if (ram_request !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ram_request got=%b exp=0", ram_request);
    end
    tests_run++;
    if (upstream_address_ready !== 3'b000) begin
      tests_failed++; $display("FAIL reset_address_ready got=%b exp=000", upstream_address_ready);
    end
    tests_run++;
    if (upstream_data_ready !== 3'b000) begin
      tests_failed++; $display("FAIL reset_data_ready got=%b exp=000", upstream_data_ready);
    end
    step();
    tests_run++;
    if (protocol_error !== 1'b0) begin
      tests_failed++; $display("FAIL reset_protocol_error got=%b exp=0", protocol_error);
    end
    reset = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_round_robin();
    int ar_count [N];
    for (int c = 0; c < N; c++) ar_count[c] = 0;
    upstream_request = 3'b111;
    ram_address_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      ram_data_ready = (k > 0);
      @(negedge clock);
      for (int c = 0; c < N; c++) ar_count[c] += int'(upstream_address_ready[c]);
      tests_run++;
      if (upstream_address_ready !== 3'(1 << (k % 3))) begin
        tests_failed++;
        $display("FAIL rr_grant cycle=%0d got=%b exp=%b", k, upstream_address_ready, 3'(1 << (k % 3)));
      end
      tests_run++;
      if (ram_address !== chan_addr(k % 3)) begin
        tests_failed++; $display("FAIL rr_address cycle=%0d got=%h exp=%h", k, ram_address, chan_addr(k % 3));
      end
      if (k > 0) begin
        tests_run++;
        if (upstream_data_ready !== 3'(1 << ((k - 1) % 3))) begin
          tests_failed++;
          $display("FAIL rr_response cycle=%0d got=%b exp=%b", k, upstream_data_ready, 3'(1 << ((k - 1) % 3)));
        end
      end
      step();
    end
    for (int c = 0; c < N; c++) begin
      tests_run++;
      if (ar_count[c] !== 3) begin
        tests_failed++; $display("FAIL rr_fairness ch=%0d got=%0d exp=3", c, ar_count[c]);
      end
    end
    upstream_request = '0;
    ram_address_ready = 1'b0;
    ram_data_ready = 1'b1;
    @(negedge clock);
    tests_run++;
    if (upstream_data_ready !== 3'b100) begin
      tests_failed++; $display("FAIL rr_drain got=%b exp=100", upstream_data_ready);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_lock();
    logic [N-1:0] req_seq [5] = '{3'b010, 3'b011, 3'b011, 3'b011, 3'b001};
    logic         rar_seq [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [N-1:0] ar_exp  [5] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b001};
    int           ch_exp  [5] = '{1, 1, 1, 1, 0};
    for (int k = 0; k < 5; k++) begin
      upstream_request = req_seq[k];
      ram_address_ready = rar_seq[k];
      @(negedge clock);
      tests_run++;
      if (ram_address !== chan_addr(ch_exp[k]) || ram_request !== 1'b1) begin
        tests_failed++;
        $display("FAIL lock_address cycle=%0d got=%h req=%b exp=%h req=1", k, ram_address, ram_request, chan_addr(ch_exp[k]));
      end
      tests_run++;
      if (upstream_address_ready !== ar_exp[k]) begin
        tests_failed++; $display("FAIL lock_grant cycle=%0d got=%b exp=%b", k, upstream_address_ready, ar_exp[k]);
      end
      step();
    end
    idle_inputs();
    ram_data_ready = 1'b1;
    @(negedge clock);
    tests_run++;
    if (upstream_data_ready !== 3'b010) begin
      tests_failed++; $display("FAIL lock_resp1 got=%b exp=010", upstream_data_ready);
    end
    step();
    @(negedge clock);
    tests_run++;
    if (upstream_data_ready !== 3'b001) begin
      tests_failed++; $display("FAIL lock_resp0 got=%b exp=001", upstream_data_ready);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_ordering();
    ram_address_ready = 1'b1;
    upstream_request = 3'b001;
    @(negedge clock);
    tests_run++;
    if (upstream_address_ready !== 3'b001) begin
      tests_failed++; $display("FAIL order_issue0 got=%b exp=001", upstream_address_ready);
    end
    step();
    upstream_request = 3'b010;
    @(negedge clock);
    tests_run++;
    if (upstream_address_ready !== 3'b010) begin
      tests_failed++; $display("FAIL order_issue1 got=%b exp=010", upstream_address_ready);
    end
    step();
    idle_inputs();
    ram_data_ready = 1'b1;
    ram_read_data = 32'hAAAA_0000;
    @(negedge clock);
    tests_run++;
    if (upstream_data_ready !== 3'b001 || upstream_read_data !== 32'hAAAA_0000) begin
      tests_failed++;
      $display("FAIL order_resp0 got=%b/%h exp=001/aaaa0000", upstream_data_ready, upstream_read_data);
    end
    step();
    ram_read_data = 32'hBBBB_1111;
    @(negedge clock);
    tests_run++;
    if (upstream_data_ready !== 3'b010 || upstream_read_data !== 32'hBBBB_1111) begin
      tests_failed++;
      $display("FAIL order_resp1 got=%b/%h exp=010/bbbb1111", upstream_data_ready, upstream_read_data);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_full_fifo();
    logic [N-1:0] push_exp  [4] = '{3'b100, 3'b001, 3'b010, 3'b100};
    logic [N-1:0] drain_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    upstream_request = 3'b111;
    ram_address_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      tests_run++;
      if (upstream_address_ready !== push_exp[k]) begin
        tests_failed++; $display("FAIL full_push%0d got=%b exp=%b", k, upstream_address_ready, push_exp[k]);
      end
      step();
    end
    @(negedge clock);
    tests_run++;
    if (ram_request !== 1'b0 || upstream_address_ready !== 3'b000) begin
      tests_failed++; $display("FAIL full_blocked got=%b/%b exp=0/000", ram_request, upstream_address_ready);
    end
    step();
    ram_data_ready = 1'b1;
    @(negedge clock);
    tests_run++;
    if (ram_request !== 1'b0 || upstream_data_ready !== 3'b100) begin
      tests_failed++; $display("FAIL full_pop_cycle got=%b/%b exp=0/100", ram_request, upstream_data_ready);
    end
    step();
    ram_data_ready = 1'b0;
    @(negedge clock);
    tests_run++;
    if (ram_request !== 1'b1 || upstream_address_ready !== 3'b001) begin
      tests_failed++; $display("FAIL full_reopen got=%b/%b exp=1/001", ram_request, upstream_address_ready);
    end
    step();
    idle_inputs();
    ram_data_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      tests_run++;
      if (upstream_data_ready !== drain_exp[k]) begin
        tests_failed++; $display("FAIL full_drain%0d got=%b exp=%b", k, upstream_data_ready, drain_exp[k]);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_protocol_error();
    ram_data_ready = 1'b1;
    @(negedge clock);
    tests_run++;
    if (upstream_data_ready !== 3'b000 || protocol_error !== 1'b0) begin
      tests_failed++; $display("FAIL perr_orphan got=%b/%b exp=000/0", upstream_data_ready, protocol_error);
    end
    step();
    ram_data_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      tests_run++;
      if (protocol_error !== 1'b1) begin
        tests_failed++; $display("FAIL perr_sticky cycle=%0d got=%b exp=1", k, protocol_error);
      end
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if (protocol_error !== 1'b0) begin
      tests_failed++; $display("FAIL perr_clear got=%b exp=0", protocol_error);
    end
    step();
  endtask

  task automatic test_mid_reset();
    ram_address_ready = 1'b1;
    upstream_request = 3'b001;
    step();
    upstream_request = 3'b010;
    step();
    reset = 1'b1;
    upstream_request = 3'b111;
    ram_data_ready = 1'b1;
    @(negedge clock);
    tests_run++;
    if ({ram_request, upstream_address_ready, upstream_data_ready} !== 7'b0) begin
      tests_failed++;
      $display("FAIL midrst_readies got=%b/%b/%b exp=0/000/000", ram_request, upstream_address_ready, upstream_data_ready);
    end
    step();
    reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    tests_run++;
    if (protocol_error !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_error_cleared got=%b exp=0", protocol_error);
    end
    step();
    ram_data_ready = 1'b1;
    @(negedge clock);
    tests_run++;
    if (upstream_data_ready !== 3'b000) begin
      tests_failed++; $display("FAIL midrst_late_resp got=%b exp=000", upstream_data_ready);
    end
    step();
    ram_data_ready = 1'b0;
    @(negedge clock);
    tests_run++;
    if (protocol_error !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_late_error got=%b exp=1", protocol_error);
    end
    step();
  endtask

  task automatic test_random();
    int           m_ptr, m_lock, m_lock_idx, g;
    int           m_q [$];
    logic         m_err;
    logic         e_req;
    logic [N-1:0] e_ar, e_dr;
    logic [AW+DW+SW+2:0] e_mux, a_mux;
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;
    m_ptr = 0; m_lock = 0; m_lock_idx = 0; m_err = 1'b0;
    m_q.delete();
    for (int k = 0; k < 400; k++) begin
      upstream_request = N'($urandom_range(0, 7));
      upstream_write   = N'($urandom_range(0, 7));
      for (int c = 0; c < N; c++) begin
        upstream_address[c*AW +: AW]      = $urandom;
        upstream_write_data[c*DW +: DW]   = $urandom;
        upstream_write_strobe[c*SW +: SW] = SW'($urandom_range(0, 15));
        upstream_size[2*c +: 2]           = 2'($urandom_range(0, 3));
      end
      ram_address_ready = ($urandom_range(0, 3) != 0);
      ram_data_ready = (m_q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 40) == 0);
      ram_read_data = $urandom;

      g = -1;
      if (m_lock != 0) g = m_lock_idx;
      else for (int i = 0; i < N; i++)
        if (g < 0 && upstream_request[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      e_req = (g >= 0) && (m_q.size() < D);
      e_ar = (e_req && ram_address_ready) ? N'(1 << g) : '0;
      e_dr = (ram_data_ready && m_q.size() > 0) ? N'(1 << m_q[0]) : '0;
      e_mux = '0;
      if (g >= 0)
        e_mux = {upstream_write[g], upstream_size[2*g +: 2], upstream_address[g*AW +: AW],
                 upstream_write_data[g*DW +: DW], upstream_write_strobe[g*SW +: SW]};

      @(negedge clock);
      a_mux = {ram_write, ram_size, ram_address, ram_write_data, ram_write_strobe};
      tests_run++;
      if ({ram_request, upstream_address_ready} !== {e_req, e_ar}) begin
        tests_failed++;
        $display("FAIL rand_request cycle=%0d got=%b/%b exp=%b/%b", k, ram_request, upstream_address_ready, e_req, e_ar);
      end
      tests_run++;
      if (upstream_data_ready !== e_dr || upstream_read_data !== ram_read_data) begin
        tests_failed++;
        $display("FAIL rand_response cycle=%0d got=%b/%h exp=%b/%h", k, upstream_data_ready, upstream_read_data, e_dr, ram_read_data);
      end
      tests_run++;
      if (a_mux !== e_mux) begin
        tests_failed++; $display("FAIL rand_mux cycle=%0d got=%h exp=%h", k, a_mux, e_mux);
      end
      tests_run++;
      if (protocol_error !== m_err) begin
        tests_failed++; $display("FAIL rand_error cycle=%0d got=%b exp=%b", k, protocol_error, m_err);
      end

      if (ram_data_ready) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (e_req && ram_address_ready) begin
        m_q.push_back(g);
        m_ptr = (g + 1) % N;
        m_lock = 0;
      end else if (e_req) begin
        m_lock = 1;
        m_lock_idx = g;
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    upstream_address = '0;
    upstream_write_data = '0;
    upstream_write_strobe = '0;
    upstream_size = '0;
    idle_inputs();
    load_fields();
    step();
    test_reset();
    test_round_robin();
    test_lock();
    test_ordering();
    test_full_fifo();
    test_protocol_error();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
